reg_file_write_arbiter: RTL and testbench

Shares the register file's two byte-wide write lanes among several writeback requesters: ALU, load unit, and any added sources. Each cycle it picks requesters round-robin, packs up to two compatible byte writes (or one word write) into a single register-file write, and drives the input decoder's `wr_en`/`wr_addr`/`data_in` from registered outputs. It sits between the execute/writeback stage and the register file input decoder.

---
 rtl/reg_file_write_arbiter.sv | 125 ++++++++++++
 tb/tb_reg_file_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_arbiter.sv
// ============================================================================
// Module      : reg_file_write_arbiter
// Description : Round-robin arbiter packing writeback requests into one
//               registered two-lane (byte) register-file write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_write_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_reg,
  input  logic [2*NUM_REQ-1:0]  req_mode,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [1:0]            wr_en,
  output logic [9:0]            wr_addr,
  output logic [15:0]           data_in,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      w_rr_next;
  logic [NUM_REQ-1:0] w_grant;
  logic [1:0]         w_wr_en;
  logic [9:0]         w_wr_addr;
  logic [15:0]        w_data;
  logic               w_have_p;
  logic               w_p_hi;
  logic               w_done;
  logic               w_any;
  logic [3:0]         w_p_reg;
  logic [1:0]         w_mode;
  logic [3:0]         w_reg;
  logic [15:0]        w_din;
  int                 w_idx;
  int                 w_last;

  // Single pass in round-robin order: no-ops ahead of the primary are consumed,
  // the first real request becomes the primary, then one compatible byte pairs.
  always_comb begin
    w_grant   = '0;
    w_wr_en   = 2'b00;
    w_wr_addr = '0;
    w_data    = '0;
    w_have_p  = 1'b0;
    w_p_hi    = 1'b0;
    w_p_reg   = '0;
    w_done    = 1'b0;
    w_any     = 1'b0;
    w_last    = 0;
    w_idx     = 0;
    w_mode    = 2'b00;
    w_reg     = '0;
    w_din     = '0;
    if (!hold && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx  = (int'(r_rr_ptr) + k) % NUM_REQ;
        w_mode = req_mode[2*w_idx +: 2];
        w_reg  = req_reg[4*w_idx +: 4];
        w_din  = req_data[16*w_idx +: 16];
        if (req_valid[w_idx] && !w_done) begin
          if (!w_have_p) begin
            w_grant[w_idx] = 1'b1;
            w_last         = w_idx;
            w_any          = 1'b1;
            if (w_mode == 2'b11) begin
              w_wr_en   = 2'b11;
              w_wr_addr = {1'b1, w_reg, 1'b0, w_reg};
              w_data    = w_din;
              w_done    = 1'b1;
            end else if (w_mode != 2'b00) begin
              w_have_p       = 1'b1;
              w_p_reg        = w_reg;
              w_p_hi         = w_mode[1];
              w_wr_en[0]     = 1'b1;
              w_wr_addr[3:0] = w_reg;
              w_wr_addr[4]   = w_mode[1];
              w_data[7:0]    = w_din[7:0];
            end
          end else if (w_mode == 2'b01 || w_mode == 2'b10) begin
            // Same register may only pair as low-then-high byte.
            if (w_reg != w_p_reg || (!w_p_hi && w_mode[1])) begin
              w_grant[w_idx] = 1'b1;
              w_last         = w_idx;
              w_wr_en[1]     = 1'b1;
              w_wr_addr[8:5] = w_reg;
              w_wr_addr[9]   = w_mode[1];
              w_data[15:8]   = w_din[7:0];
              w_done         = 1'b1;
            end
          end
        end
      end
    end
    w_rr_next = w_any ? PW'((w_last + 1) % NUM_REQ) : r_rr_ptr;
  end

  assign req_ready = w_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      wr_en    <= 2'b00;
      wr_addr  <= '0;
      data_in  <= '0;
      busy     <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_next;
      wr_en    <= w_wr_en;
      wr_addr  <= w_wr_addr;
      data_in  <= w_data;
      busy     <= |(req_valid & ~w_grant);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_file_write_arbiter
// Description : Scoreboard bench for reg_file_write_arbiter with a queue-based
//               reference model and randomized plus directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_write_arbiter;

  localparam int N = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_reg;
  logic [2*N-1:0]  req_mode;
  logic [16*N-1:0] req_data;
  logic [1:0]      wr_en;
  logic [9:0]      wr_addr;
  logic [15:0]     data_in;
  logic            busy;

  reg_file_write_arbiter #(.NUM_REQ(N)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg),
    .req_mode(req_mode), .req_data(req_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  en;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;
  bit   mon_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the requesters in rotation order as a queue of indices.
  task automatic model(output logic [N-1:0] g, output exp_t e);
    int ord[$];
    int i, p, last;
    logic [1:0] pm, sm;
    logic [3:0] preg, sreg;
    g = '0;
    e = '0;
    if (hold) begin
      e.bsy = |req_valid;
      return;
    end
    for (int k = 0; k < N; k++) ord.push_back((mptr + k) % N);
    p = -1;
    last = -1;
    while (ord.size() > 0 && p < 0) begin
      i = ord.pop_front();
      if (!req_valid[i]) continue;
      g[i] = 1'b1;
      last = i;
      if (req_mode[2*i +: 2] != 2'b00) p = i;
    end
    if (p >= 0) begin
      pm   = req_mode[2*p +: 2];
      preg = req_reg[4*p +: 4];
      if (pm == 2'b11) begin
        e.en   = 2'b11;
        e.addr = {1'b1, preg, 1'b0, preg};
        e.data = req_data[16*p +: 16];
      end else begin
        e.en[0]     = 1'b1;
        e.addr[3:0] = preg;
        e.addr[4]   = (pm == 2'b10);
        e.data[7:0] = req_data[16*p +: 8];
        while (ord.size() > 0) begin
          i    = ord.pop_front();
          sm   = req_mode[2*i +: 2];
          sreg = req_reg[4*i +: 4];
          if (!req_valid[i] || sm == 2'b00 || sm == 2'b11) continue;
          if (sreg != preg || (pm == 2'b01 && sm == 2'b10)) begin
            g[i] = 1'b1;
            last = i;
            e.en[1]      = 1'b1;
            e.addr[8:5]  = sreg;
            e.addr[9]    = (sm == 2'b10);
            e.data[15:8] = req_data[16*i +: 8];
            break;
          end
        end
      end
    end
    e.bsy = |(req_valid & ~g);
    if (last >= 0) mptr = (last + 1) % N;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_reg   = '0;
    req_mode  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] m, input logic [3:0] r, input logic [15:0] d);
    req_valid[i]         = 1'b1;
    req_mode[2*i +: 2]   = m;
    req_reg[4*i +: 4]    = r;
    req_data[16*i +: 16] = d;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic [N-1:0] g;
    exp_t e;
    #1;
    model(g, e);
    check("req_ready", 32'(req_ready), 32'(g));
    sb.push_back(e);
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_on && sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_en",   32'(wr_en),   32'(e.en));
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("data_in", 32'(data_in), 32'(e.data));
        check("busy",    32'(busy),    32'(e.bsy));
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    hold  = 1'b0;
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 2'b11, 4'(i), 16'h1111);
    #2;
    check("reset_ready",   32'(req_ready), 32'h0);
    check("reset_wr_en",   32'(wr_en),     32'h0);
    check("reset_wr_addr", 32'(wr_addr),   32'h0);
    check("reset_data_in", 32'(data_in),   32'h0);
    check("reset_busy",    32'(busy),      32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_reqs();

    // Single word, then idle so outputs return to zero.
    set_req(0, 2'b11, 4'd5, 16'hBEEF);
    step();
    clear_reqs();
    step();
    // Realign rotation to requester 0, then a low/high byte pair.
    set_req(2, 2'b11, 4'd9, 16'h0F0F);
    step();
    clear_reqs();
    set_req(0, 2'b01, 4'd2, 16'h0012);
    set_req(1, 2'b10, 4'd7, 16'h0034);
    step();
    clear_reqs();
    set_req(2, 2'b11, 4'd1, 16'h2222);
    step();
    clear_reqs();
    // Incompatible same-byte pair: requester 1 is skipped and stalls.
    set_req(0, 2'b10, 4'd3, 16'h00AA);
    set_req(1, 2'b10, 4'd3, 16'h00BB);
    set_req(2, 2'b01, 4'd4, 16'h00CC);
    step();
    clear_reqs();
    set_req(1, 2'b10, 4'd3, 16'h00BB);
    step();
    clear_reqs();
    // All words continuously.
    for (int i = 0; i < N; i++) set_req(i, 2'b11, 4'(i + 8), 16'(16'hA000 + i));
    repeat (6) step();
    clear_reqs();
    // Hold with requester 1 pending.
    hold = 1'b1;
    set_req(1, 2'b11, 4'd6, 16'h5A5A);
    repeat (2) step();
    hold = 1'b0;
    step();
    clear_reqs();
    step();

    // Grant, then an asynchronous reset pulse between clock edges.
    set_req(0, 2'b11, 4'd12, 16'hCAFE);
    set_req(1, 2'b11, 4'd13, 16'hD00D);
    step();
    clear_reqs();
    mon_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_wr_en",   32'(wr_en),   32'h0);
    check("async_wr_addr", 32'(wr_addr), 32'h0);
    check("async_data_in", 32'(data_in), 32'h0);
    for (int i = 0; i < N; i++) set_req(i, 2'b11, 4'(i + 1), 16'(16'h7000 + i));
    #1;
    check("reset_ready_held", 32'(req_ready), 32'h0);
    sb.delete();
    @(negedge clock);
    reset  = 1'b0;
    mptr   = 0;
    mon_on = 1'b1;
    step();
    clear_reqs();

    // Randomized traffic with a small register range to force collisions.
    repeat (400) begin
      clear_reqs();
      hold = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0)
          set_req(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom));
      end
      step();
    end
    hold = 1'b0;
    clear_reqs();
    repeat (2) step();
    @(posedge clock);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
